// File: rtl/tristate_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tristate_arb_pkg
// Shared types and default parameters for the tristate bus arbiter.
//   arb_state_t      : arbiter FSM state (IDLE, GRANT, TURN)
//   DEF_N_REQ        : default number of requesters
//   DEF_MAX_HOLD     : default maximum tenure in cycles
//   DEF_TURN_CYCLES  : default all-off turnaround length in cycles
// ---------------------------------------------------------------------------
package tristate_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_t;

   localparam int DEF_N_REQ       = 4;
   localparam int DEF_MAX_HOLD    = 8;
   localparam int DEF_TURN_CYCLES = 1;

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Starting at i_ptr and moving upwards
// (modulo N_REQ), the first requester with i_req set wins.
//   i_req     : request vector
//   i_ptr     : highest-priority index for this pick
//   o_winner  : winning index (0 when nothing is requested)
//   o_any     : at least one request is present
// ---------------------------------------------------------------------------
module rr_pick
   import tristate_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ
) (
   input  logic [N_REQ-1:0]         i_req,
   input  logic [$clog2(N_REQ)-1:0] i_ptr,
   output logic [$clog2(N_REQ)-1:0] o_winner,
   output logic                     o_any
);

   localparam int IW = $clog2(N_REQ);

   int w_dist;
   int w_best;

   // Each requester's distance from the pointer; the smallest distance wins.
   always_comb begin
      o_winner = '0;
      o_any    = |i_req;
      w_best   = N_REQ;
      w_dist   = 0;
      for (int j = 0; j < N_REQ; j++) begin
         w_dist = j - int'(i_ptr);
         if (w_dist < 0) w_dist = w_dist + N_REQ;
         if (i_req[j] && (w_dist < w_best)) begin
            w_best   = w_dist;
            o_winner = IW'(j);
         end
      end
   end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tristate_bus_arbiter
// Round-robin owner selection for a shared tristate bus. Drives one enable
// per tristate driver, guarantees at most one enable at a time, inserts
// TURN_CYCLES all-off cycles between owners and limits tenure to MAX_HOLD.
//   i_clk        : rising-edge clock
//   i_reset      : asynchronous active-high reset
//   i_req        : level requests, one per driver
//   o_en         : one-hot-or-zero driver enables
//   o_gnt_id     : current owner index (meaningful while o_gnt_valid)
//   o_gnt_valid  : some enable is high
//   o_bus_idle   : no owner and no turnaround in progress
// ---------------------------------------------------------------------------
module tristate_bus_arbiter
   import tristate_arb_pkg::*;
#(
   parameter int N_REQ       = DEF_N_REQ,
   parameter int MAX_HOLD    = DEF_MAX_HOLD,
   parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [N_REQ-1:0]         i_req,
   output logic [N_REQ-1:0]         o_en,
   output logic [$clog2(N_REQ)-1:0] o_gnt_id,
   output logic                     o_gnt_valid,
   output logic                     o_bus_idle
);

   localparam int IW = $clog2(N_REQ);
   localparam int HW = (MAX_HOLD    > 1) ? $clog2(MAX_HOLD)    : 1;
   localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

   arb_state_t       r_state;
   logic [N_REQ-1:0] r_en;
   logic [IW-1:0]    r_gnt_id;
   logic             r_gnt_valid;
   logic             r_bus_idle;
   logic [IW-1:0]    r_rr_ptr;
   logic [HW-1:0]    r_hold_cnt;
   logic [TW-1:0]    r_turn_cnt;

   logic [IW-1:0]    w_winner;
   logic             w_any;
   logic             w_pick_point;
   logic             w_owner_drop;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .i_req    (i_req),
      .i_ptr    (r_rr_ptr),
      .o_winner (w_winner),
      .o_any    (w_any)
   );

   // A new owner may only be chosen from IDLE or on the final TURN cycle;
   // any unexpected state encoding is treated like IDLE so it self-recovers.
   assign w_pick_point = ((r_state != GRANT) && (r_state != TURN)) ||
                         ((r_state == TURN) && (r_turn_cnt == TURN_LAST));
   assign w_owner_drop = !i_req[r_gnt_id];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_en        <= '0;
         r_gnt_id    <= '0;
         r_gnt_valid <= 1'b0;
         r_bus_idle  <= 1'b1;
         r_rr_ptr    <= '0;
         r_hold_cnt  <= '0;
         r_turn_cnt  <= '0;
      end else if (w_pick_point) begin
         if (w_any) begin
            r_state     <= GRANT;
            r_en        <= {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
            r_gnt_id    <= w_winner;
            r_gnt_valid <= 1'b1;
            r_bus_idle  <= 1'b0;
            r_rr_ptr    <= (w_winner == IW'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
            r_hold_cnt  <= '0;
         end else begin
            r_state     <= IDLE;
            r_en        <= '0;
            r_gnt_valid <= 1'b0;
            r_bus_idle  <= 1'b1;
         end
      end else if (r_state == GRANT) begin
         // Drop and hold expiry in the same cycle collapse into one exit.
         if (w_owner_drop || (r_hold_cnt == HOLD_LAST)) begin
            r_state     <= TURN;
            r_en        <= '0;
            r_gnt_valid <= 1'b0;
            r_turn_cnt  <= '0;
         end else begin
            r_hold_cnt  <= r_hold_cnt + 1'b1;
         end
      end else begin
         r_turn_cnt <= r_turn_cnt + 1'b1;
      end
   end

   assign o_en        = r_en;
   assign o_gnt_id    = r_gnt_id;
   assign o_gnt_valid = r_gnt_valid;
   assign o_bus_idle  = r_bus_idle;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tristate_bus_arbiter
// Two arbiter instances: A uses the default parameters (4, 8, 1), B uses
// (4, MAX_HOLD=1, TURN_CYCLES=3). Both are compared every cycle against a
// tenure/gap model of the bus ownership rules.
// ---------------------------------------------------------------------------
module tb_tristate_bus_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req_a, req_b;
   logic [3:0] en_a, en_b;
   logic [1:0] gid_a, gid_b;
   logic       gv_a, gv_b, idle_a, idle_b;

   int n_vec = 0;
   int n_err = 0;

   // Model: owner (-1 = none), cycles held so far, remaining gap cycles, next priority.
   int owner  [2];
   int tenure [2];
   int gap    [2];
   int rr     [2];
   int mh     [2] = '{8, 1};
   int tc     [2] = '{1, 3};

   always #5 clk = ~clk;

   tristate_bus_arbiter dut_a (
      .i_clk(clk), .i_reset(reset), .i_req(req_a), .o_en(en_a),
      .o_gnt_id(gid_a), .o_gnt_valid(gv_a), .o_bus_idle(idle_a)
   );

   tristate_bus_arbiter #(.N_REQ(4), .MAX_HOLD(1), .TURN_CYCLES(3)) dut_b (
      .i_clk(clk), .i_reset(reset), .i_req(req_b), .o_en(en_b),
      .o_gnt_id(gid_b), .o_gnt_valid(gv_b), .o_bus_idle(idle_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         owner[k] = -1; tenure[k] = 0; gap[k] = 0; rr[k] = 0;
      end
   endtask

   task automatic model_pick(input int k, input logic [3:0] r);
      bit found = 0;
      for (int j = 0; j < 4; j++) begin
         int c = (rr[k] + j) % 4;
         if (!found && r[c]) begin
            found = 1; owner[k] = c; tenure[k] = 1; rr[k] = (c + 1) % 4;
         end
      end
   endtask

   task automatic model_step(input int k, input logic [3:0] r);
      if (owner[k] >= 0) begin
         if (!r[owner[k]] || tenure[k] == mh[k]) begin
            owner[k] = -1; gap[k] = tc[k];
         end else begin
            tenure[k]++;
         end
      end else begin
         if (gap[k] > 0) gap[k]--;
         if (gap[k] == 0) model_pick(k, r);
      end
   endtask

   function automatic logic [31:0] exp_en(input int k);
      return (owner[k] >= 0) ? (32'd1 << owner[k]) : 32'd0;
   endfunction

   task automatic check_all();
      chk("en_a", 32'(en_a), exp_en(0));
      chk("gv_a", 32'(gv_a), 32'(owner[0] >= 0));
      chk("idle_a", 32'(idle_a), 32'(owner[0] < 0 && gap[0] == 0));
      chk("onehot_a", 32'(en_a & (en_a - 4'd1)), 32'd0);
      if (owner[0] >= 0) chk("gid_a", 32'(gid_a), 32'(owner[0]));
      chk("en_b", 32'(en_b), exp_en(1));
      chk("gv_b", 32'(gv_b), 32'(owner[1] >= 0));
      chk("idle_b", 32'(idle_b), 32'(owner[1] < 0 && gap[1] == 0));
      if (owner[1] >= 0) chk("gid_b", 32'(gid_b), 32'(owner[1]));
   endtask

   task automatic cycle(input logic [3:0] ra, input logic [3:0] rb);
      req_a = ra;
      req_b = rb;
      @(posedge clk);
      model_step(0, ra);
      model_step(1, rb);
      #1;
      check_all();
   endtask

   initial begin
      int waited;
      logic [3:0] ra, rb;
      reset = 1'b1;
      req_a = '0;
      req_b = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_en_a", 32'(en_a), 32'd0);
      chk("rst_gid_a", 32'(gid_a), 32'd0);
      chk("rst_gv_a", 32'(gv_a), 32'd0);
      chk("rst_idle_a", 32'(idle_a), 32'd1);
      chk("rst_en_b", 32'(en_b), 32'd0);
      reset = 1'b0;

      // Sole requester 0; B sees two requesters with 1-cycle tenures.
      repeat (20) cycle(4'b0001, 4'b0011);
      repeat (3)  cycle(4'b0000, 4'b0011);
      // Everyone requesting: rotation 0,1,2,3,0.
      repeat (40) cycle(4'b1111, 4'b0011);
      repeat (3)  cycle(4'b0000, 4'b0000);
      // Short tenure then back to idle.
      repeat (3)  cycle(4'b0100, 4'b0000);
      repeat (4)  cycle(4'b0000, 4'b0000);
      chk("idle_after_short", 32'(idle_a), 32'd1);
      // Owner 0 drops while 1 and 2 wait.
      repeat (2)  cycle(4'b0001, 4'b0000);
      repeat (2)  cycle(4'b0111, 4'b0000);
      repeat (20) cycle(4'b0110, 4'b0000);
      repeat (4)  cycle(4'b0000, 4'b0000);

      // Reset in the 4th cycle of a tenure must clear enables without an edge.
      waited = 0;
      cycle(4'b1111, 4'b1111);
      while (!(owner[0] >= 0 && tenure[0] == 4) && waited < 40) begin
         cycle(4'b1111, 4'b1111);
         waited++;
      end
      if (waited >= 40) chk("mid_grant_wait", 32'd0, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      chk("async_en_a", 32'(en_a), 32'd0);
      chk("async_gv_a", 32'(gv_a), 32'd0);
      chk("async_idle_a", 32'(idle_a), 32'd1);
      @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;
      cycle(4'b1010, 4'b1010);
      chk("post_rst_owner", 32'(en_a), 32'h2);

      // Randomized sticky requests.
      ra = 4'b1010;
      rb = 4'b1010;
      for (int n = 0; n < 400; n++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(7) == 0) ra[b] = ~ra[b];
            if ($urandom_range(5) == 0) rb[b] = ~rb[b];
         end
         cycle(ra, rb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Round-robin arbiter that shares one WIDTH-bit tristate bus among N_REQ `tristate` drivers. Each requester owns one `tristate` instance; this block generates the per-driver `en` lines so that at most one driver is enabled in any cycle. It inserts a guaranteed all-off turnaround between owners and caps each tenure at MAX_HOLD cycles.

## Interface
- N_REQ, 4: number of requesters/drivers, 2..8
- MAX_HOLD, 8: maximum consecutive cycles one owner keeps `en`, ≥1
- TURN_CYCLES, 1: all-off cycles between tenures, ≥1
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  level request; req[i] high = driver i wants the bus
- en  out  N_REQ  one-hot-or-zero enable, wired to `en` of tristate instance i
- gnt_id  out  $clog2(N_REQ)  index of current owner, valid only while gnt_valid
- gnt_valid  out  1  high while some en bit is high
- bus_idle  out  1  high in IDLE state (no owner, no turnaround)

## Operation
- States: IDLE, GRANT, TURN (3-state FSM, registered outputs).
- Reset (async): state=IDLE, en=0, gnt_id=0, gnt_valid=0, bus_idle=1, rr_ptr=0, hold_cnt=0, turn_cnt=0.
- IDLE: if |req, pick winner by round-robin from rr_ptr (search rr_ptr, rr_ptr+1, … mod N_REQ) -> GRANT; en[winner]=1, gnt_id=winner, rr_ptr=winner+1 mod N_REQ, hold_cnt=0. Else stay.
- GRANT: hold_cnt increments each cycle. Exit to TURN when req[gnt_id]==0 or hold_cnt==MAX_HOLD-1; en=0, turn_cnt=0.
- TURN: en=0 for exactly TURN_CYCLES cycles. On the last TURN cycle: if |req, pick winner as in IDLE and go straight to GRANT; else go to IDLE.
- Requests from non-owners during GRANT/TURN are only sampled at the pick point; no preemption.
- A dropped owner request and hold expiry in the same cycle produce a single exit to TURN.
- en never has more than one bit set; en never switches directly from one owner to another.

## Timing
- Grant latency from IDLE: req sampled high at edge k -> en bit high from edge k (visible cycle after edge), i.e. 1 cycle.
- Tenure length: en[i] high for min(cycles until req[i] sampled low, MAX_HOLD) cycles; with req held, exactly MAX_HOLD.
- Release latency: owner req sampled low at edge k -> en low after edge k.
- Owner-to-owner gap: exactly TURN_CYCLES cycles with en==0.
- Sole continuous requester: MAX_HOLD on, TURN_CYCLES off, repeat.
- Reset asserted mid-GRANT: en drops to 0 immediately (asynchronously), not at next edge; after deassert, first grant favours index 0.
- gnt_valid == |en; bus_idle high only in IDLE (low in TURN).

## Structure
- Package `tristate_arb_pkg`: state enum (IDLE, GRANT, TURN) and default parameter constants.
- One sub-module `rr_pick`: combinational round-robin selector (req, rr_ptr -> winner index, any_valid). FSM, counters and output registers in the top.
- Bus itself (tristate instances, shared wire) lives in the parent; this block only drives enables.

## Test plan
- Reset then req=4'b0001 held 20 cycles -> en=0001 for 8 cycles, 0000 for 1, 0001 for 8, …; gnt_id=0.
- req=4'b1111 held -> grants in order 0,1,2,3,0 each 8 cycles, single all-zero cycle between; en never two bits set.
- req=4'b0100 for 3 cycles then 0 -> en=0100 for exactly 3 cycles, then 1 TURN cycle, then IDLE (bus_idle=1).
- During owner 0 tenure, raise req[2] and req[1]; drop req[0] -> after 1-cycle gap owner=1 (rr_ptr=1), then 2.
- Assert reset in 4th cycle of a grant -> en=0 same cycle without clock edge; after release with req=4'b1010 first owner is 1.
- TURN_CYCLES=3, MAX_HOLD=1, req=4'b0011 -> pattern en 0001, 000×3, 0010, 000×3, 0001.
